// File: rtl/cvsd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : cvsd_decoder
//  Description : CVSD (continuously variable slope delta) bit-stream decoder.
//                Rebuilds the encoder's integrator value, smooths it with a
//                4-sample moving average, flags slope overload and mutes
//                itself after a long gap in the incoming bit stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module cvsd_decoder #(
    parameter int BETA     = 48,   // step decay numerator, denominator is 50
    parameter int DELTA    = 1,    // step increment on a three-bit run
    parameter int STEP0    = 10,   // reset / resync step size
    parameter int IDLE_MAX = 200   // idle cycles before muting
) (
    input  logic       clk_10k,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] xp,
    output logic [7:0] y,
    output logic       y_valid,
    output logic       slope_ovl,
    output logic       muted
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [7:0]  c_mid      = 8'd128;
    localparam logic [9:0]  c_sum_rst  = 10'd512;
    localparam logic [7:0]  c_step0    = 8'(STEP0);
    localparam logic [7:0]  c_delta    = 8'(DELTA);
    localparam logic [7:0]  c_idle_max = 8'(IDLE_MAX);
    localparam logic [15:0] c_beta     = 16'(BETA);
    localparam logic [15:0] c_den      = 16'd50;
    localparam logic [3:0]  c_ovl_thr  = 4'd8;
    localparam logic [3:0]  c_ovl_sat  = 4'hF;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_MUTE = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      state_q;
    logic        muted_q;
    logic [7:0]  idle_q;

    logic [7:0]  xp_q;
    logic [7:0]  step_q;
    logic        h1_q;
    logic        h2_q;
    logic [3:0]  ovl_cnt_q;
    logic        slope_q;

    logic [7:0]  w0_q;
    logic [7:0]  w1_q;
    logic [7:0]  w2_q;
    logic [7:0]  w3_q;
    logic [9:0]  sum_q;
    logic [7:0]  y_q;
    logic        y_valid_q;
    logic        acc1_q;   // a bit was accepted on the previous edge
    logic        acc2_q;   // the window absorbed that bit on the previous edge

    // ------------------------------------------------------------------------
    // Next-state values for an accepted bit
    // ------------------------------------------------------------------------
    logic        w_flag;
    logic [15:0] w_prod;
    logic [7:0]  w_quot;
    logic [7:0]  step_d;
    logic [7:0]  xp_d;
    logic [3:0]  ovl_cnt_d;
    logic [7:0]  w_idle_inc;
    logic        w_mute_entry;

    // Step adaptation, integrator update, run detection and mute trigger
    always_comb begin
        w_flag       = (bit_in == h1_q) && (bit_in == h2_q);
        // 16-bit product keeps BETA*255 exact before the floor division
        w_prod       = c_beta * {8'd0, step_q};
        w_quot       = 8'(w_prod / c_den);
        step_d       = w_quot + (w_flag ? c_delta : 8'd0);
        // The integrator uses the step held before this update and wraps
        xp_d         = bit_in ? (xp_q + step_q) : (xp_q - step_q);
        ovl_cnt_d    = w_flag ? ((ovl_cnt_q == c_ovl_sat) ? c_ovl_sat
                                                          : ovl_cnt_q + 4'd1)
                              : 4'd0;
        // Saturate so a long mute never wraps the idle count
        w_idle_inc   = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;
        w_mute_entry = (state_q == ST_RUN) && !bit_valid
                       && (w_idle_inc == c_idle_max);
    end

    // RUN/MUTE controller with idle-gap counter and registered muted flag
    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            muted_q <= 1'b0;
            idle_q  <= 8'd0;
        end else begin
            idle_q <= bit_valid ? 8'd0 : w_idle_inc;
            case (state_q)
                ST_RUN: begin
                    if (w_mute_entry) begin
                        state_q <= ST_MUTE;
                        muted_q <= 1'b1;
                    end
                end
                ST_MUTE: begin
                    // The waking bit itself is processed by the datapath
                    if (bit_valid) begin
                        state_q <= ST_RUN;
                        muted_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Integrator, step size, bit history and overload run counter
    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            xp_q      <= c_mid;
            step_q    <= c_step0;
            h1_q      <= 1'b1;
            h2_q      <= 1'b0;
            ovl_cnt_q <= 4'd0;
        end else if (w_mute_entry) begin
            xp_q      <= c_mid;
            step_q    <= c_step0;
            h1_q      <= 1'b1;
            h2_q      <= 1'b0;
            ovl_cnt_q <= 4'd0;
        end else if (bit_valid) begin
            xp_q      <= xp_d;
            step_q    <= step_d;
            h2_q      <= h1_q;
            h1_q      <= bit_in;
            ovl_cnt_q <= ovl_cnt_d;
        end
    end

    // Overload indicator follows the registered run count one cycle later
    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            slope_q <= 1'b0;
        end else if (w_mute_entry) begin
            slope_q <= 1'b0;
        end else begin
            slope_q <= (ovl_cnt_q >= c_ovl_thr);
        end
    end

    // Moving-average pipeline: window shift one edge after a bit, output next
    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            w0_q      <= c_mid;
            w1_q      <= c_mid;
            w2_q      <= c_mid;
            w3_q      <= c_mid;
            sum_q     <= c_sum_rst;
            y_q       <= c_mid;
            y_valid_q <= 1'b0;
            acc1_q    <= 1'b0;
            acc2_q    <= 1'b0;
        end else if (w_mute_entry) begin
            // Reload the filter and drop anything still in flight
            w0_q      <= c_mid;
            w1_q      <= c_mid;
            w2_q      <= c_mid;
            w3_q      <= c_mid;
            sum_q     <= c_sum_rst;
            y_q       <= c_mid;
            y_valid_q <= 1'b0;
            acc1_q    <= 1'b0;
            acc2_q    <= 1'b0;
        end else begin
            acc1_q    <= bit_valid;
            acc2_q    <= acc1_q;
            y_valid_q <= acc2_q;
            if (acc1_q) begin
                w0_q  <= xp_q;
                w1_q  <= w0_q;
                w2_q  <= w1_q;
                w3_q  <= w2_q;
                sum_q <= sum_q + {2'b00, xp_q} - {2'b00, w3_q};
            end
            if (acc2_q) begin
                y_q <= sum_q[9:2];
            end
        end
    end

    assign xp        = xp_q;
    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign slope_ovl = slope_q;
    assign muted     = muted_q;

endmodule
`default_nettype wire

// File: tb/tb_cvsd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cvsd_decoder
//  Description : Self-checking bench for cvsd_decoder. A behavioural model
//                tracks integrator, step, overload and mute state; expected
//                filter outputs are queued with their due cycle and matched
//                against y_valid pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cvsd_decoder;

    logic       clk_10k;
    logic       rst_n;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] xp;
    logic [7:0] y;
    logic       y_valid;
    logic       slope_ovl;
    logic       muted;

    cvsd_decoder #(
        .BETA     (48),
        .DELTA    (1),
        .STEP0    (10),
        .IDLE_MAX (200)
    ) u_dut (
        .clk_10k   (clk_10k),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .xp        (xp),
        .y         (y),
        .y_valid   (y_valid),
        .slope_ovl (slope_ovl),
        .muted     (muted)
    );

    initial begin
        clk_10k = 1'b0;
        forever #50 clk_10k = ~clk_10k;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int y_exp;
        int due;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int m_xp, m_step, m_h1, m_h2, m_cnt, m_slope, m_muted, m_idle, m_sum;
    int m_w [4];

    int alt_exp [12] = '{118, 127, 119, 126, 120, 125, 121, 124, 122, 123, 123, 123};

    task automatic check_val(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic model_reset();
        m_xp    = 128;
        m_step  = 10;
        m_h1    = 1;
        m_h2    = 0;
        m_cnt   = 0;
        m_slope = 0;
        m_muted = 0;
        m_idle  = 0;
        m_sum   = 512;
        for (int k = 0; k < 4; k++) m_w[k] = 128;
        q.delete();
    endtask

    // One clock: drive, advance the model at the edge, check at the negedge
    task automatic step(input logic bv, input logic b);
        int   flag;
        int   nx;
        int   bi;
        exp_t e;
        bit_valid = bv;
        bit_in    = b;
        @(posedge clk_10k);
        cyc++;
        bi = b ? 1 : 0;
        if (bv) begin
            flag    = (bi == m_h1 && bi == m_h2) ? 1 : 0;
            m_slope = (m_cnt >= 8) ? 1 : 0;
            nx      = b ? ((m_xp + m_step) & 255) : ((m_xp - m_step + 256) & 255);
            m_step  = ((48 * m_step) / 50 + flag) & 255;
            m_xp    = nx;
            m_h2    = m_h1;
            m_h1    = bi;
            m_cnt   = flag ? ((m_cnt == 15) ? 15 : m_cnt + 1) : 0;
            m_sum   = (m_sum + nx - m_w[3]) & 1023;
            m_w[3]  = m_w[2];
            m_w[2]  = m_w[1];
            m_w[1]  = m_w[0];
            m_w[0]  = nx;
            e.y_exp = (m_sum >> 2) & 255;
            e.due   = cyc + 2;
            q.push_back(e);
            m_idle  = 0;
            m_muted = 0;
        end else if (m_muted == 0 && m_idle + 1 == 200) begin
            model_reset();
            m_muted = 1;
            m_idle  = 200;
        end else begin
            m_slope = (m_cnt >= 8) ? 1 : 0;
            if (m_idle != 255) m_idle++;
        end
        @(negedge clk_10k);
        check_val("xp", int'(xp), m_xp);
        check_val("slope_ovl", int'(slope_ovl), m_slope);
        check_val("muted", int'(muted), m_muted);
        if (y_valid) begin
            if (q.size() == 0) begin
                check_val("yv_spurious", int'(y_valid), 0);
            end else begin
                e = q.pop_front();
                check_val("y", int'(y), e.y_exp);
                check_val("y_latency", cyc, e.due);
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            check_val("yv_missing", int'(y_valid), 1);
            void'(q.pop_front());
        end
    endtask

    // Asynchronous reset: outputs checked before any clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_xp", int'(xp), 128);
        check_val("rst_y", int'(y), 128);
        check_val("rst_y_valid", int'(y_valid), 0);
        check_val("rst_slope", int'(slope_ovl), 0);
        check_val("rst_muted", int'(muted), 0);
        model_reset();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        @(posedge clk_10k);
        cyc++;
        @(negedge clk_10k);
        rst_n = 1'b1;
    endtask

    initial begin
        logic prev;
        rst_n     = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        #5;
        do_reset();

        // Continuous ones: wrap, step steady at 9, overload rise and fall
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b1);
            if (i == 1)  check_val("ones_xp1", int'(xp), 138);
            if (i == 2)  check_val("ones_xp2", int'(xp), 147);
            if (i == 9)  check_val("ovl_before", int'(slope_ovl), 0);
            if (i == 10) check_val("ovl_rise", int'(slope_ovl), 1);
            if (i == 14) check_val("ones_xp14", int'(xp), 255);
            if (i == 15) check_val("ones_xp15_wrap", int'(xp), 8);
        end
        step(1'b1, 1'b0);
        check_val("ovl_hold_on_zero", int'(slope_ovl), 1);
        step(1'b0, 1'b0);
        check_val("ovl_fall", int'(slope_ovl), 0);

        // Idle gap long enough to mute, then resync on the next bit
        for (int i = 0; i < 198; i++) step(1'b0, 1'b0);
        check_val("mute_early", int'(muted), 0);
        step(1'b0, 1'b0);
        check_val("mute_on", int'(muted), 1);
        check_val("mute_xp", int'(xp), 128);
        check_val("mute_y", int'(y), 128);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check_val("unmute", int'(muted), 0);
        check_val("unmute_xp", int'(xp), 138);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Single bit: filter output two cycles later
        #10;
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        check_val("y30_early", int'(y_valid), 0);
        step(1'b0, 1'b0);
        check_val("y30_valid", int'(y_valid), 1);
        check_val("y30_value", int'(y), 130);
        step(1'b0, 1'b0);
        check_val("y30_pulse_end", int'(y_valid), 0);

        // Alternating bits decay the step to zero
        #10;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, (i % 2) == 1);
            check_val("alt_xp", int'(xp), alt_exp[i]);
        end

        // Reset in the middle of a ones stream with pulses in flight
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        #10;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check_val("post_rst_xp", int'(xp), 138);

        // Random stream with runs and gaps
        prev = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) prev = ~prev;
            step($urandom_range(0, 3) != 0, prev);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check_val("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
